// File: rtl/msrv32_fetch_ctrl.sv
// Instruction-fetch sequencer: in-order imem requests, 2-entry return buffer,
// stale-response dropping after redirects, and NOP-flush control for decode.
module msrv32_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out
);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [1:0]  out_cnt;
  logic [1:0]  drop_cnt;
  logic [1:0]  buf_cnt;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];

  logic        grant;
  logic        resp;
  logic        push;
  logic        pop;
  logic [1:0]  redir_cnt;
  logic [31:0] resp_pc;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_in[1:0];

  always_comb begin
    imem_req_out    = (state == RUN) && (({1'b0, out_cnt} + {1'b0, buf_cnt}) < 3'd2)
                      && !redirect_in;
    imem_addr_out   = fetch_pc;
    instr_valid_out = (buf_cnt != 2'd0) && !redirect_in;
    flush_out       = !instr_valid_out;
    instr_out       = fifo_instr[0];
    pc_out          = fifo_pc[0];
    grant           = imem_req_out && imem_gnt_in;
    resp            = imem_rvalid_in && (out_cnt != 2'd0);
    push            = resp && (drop_cnt == 2'd0);
    pop             = instr_valid_out && !stall_in;
    redir_cnt       = out_cnt - {1'b0, resp};
    // Outstanding requests are consecutive words ending just below fetch_pc,
    // so the oldest one (the one responding) sits out_cnt words back.
    resp_pc         = fetch_pc - {28'd0, out_cnt, 2'b00};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= BOOT;
      fetch_pc      <= RESET_PC;
      out_cnt       <= '0;
      drop_cnt      <= '0;
      buf_cnt       <= '0;
      fifo_pc[0]    <= '0;
      fifo_pc[1]    <= '0;
      fifo_instr[0] <= '0;
      fifo_instr[1] <= '0;
    end else if (redirect_in) begin
      buf_cnt  <= '0;
      fetch_pc <= {redirect_pc_in[31:2], 2'b00};
      out_cnt  <= redir_cnt;
      drop_cnt <= redir_cnt;
      state    <= (redir_cnt != 2'd0) ? DRAIN : RUN;
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      out_cnt <= out_cnt + {1'b0, grant} - {1'b0, resp};
      if (resp && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;

      case (state)
        BOOT:    state <= RUN;
        DRAIN:   if ((drop_cnt == 2'd0) || (resp && (drop_cnt == 2'd1))) state <= RUN;
        default: ;
      endcase

      case ({push, pop})
        2'b10: begin
          fifo_pc[buf_cnt[0]]    <= resp_pc;
          fifo_instr[buf_cnt[0]] <= imem_rdata_in;
          buf_cnt                <= buf_cnt + 2'd1;
        end
        2'b01: begin
          fifo_pc[0]    <= fifo_pc[1];
          fifo_instr[0] <= fifo_instr[1];
          buf_cnt       <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            fifo_pc[0]    <= resp_pc;
            fifo_instr[0] <= imem_rdata_in;
          end else begin
            fifo_pc[0]    <= fifo_pc[1];
            fifo_instr[0] <= fifo_instr[1];
            fifo_pc[1]    <= resp_pc;
            fifo_instr[1] <= imem_rdata_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Bench for msrv32_fetch_ctrl: directed scenarios plus a randomized run, all
// against a queue-based fetch model and an in-order memory model.
module tb_msrv32_fetch_ctrl;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        stall_in = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        flush_out;

  msrv32_fetch_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_gnt_in     (imem_gnt_in),
    .imem_rvalid_in  (imem_rvalid_in),
    .imem_rdata_in   (imem_rdata_in),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .stall_in        (stall_in),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid_out (instr_valid_out),
    .flush_out       (flush_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit gnt_always = 1'b1;
  int lat_min = 1;
  int lat_max = 1;

  typedef struct { logic [31:0] pc; bit stale; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  // Reference model: phase 0 = boot, 1 = fetching, 2 = discarding stale returns
  int          m_phase = 0;
  logic [31:0] m_fetch = TB_RESET_PC;
  out_t        m_out[$];
  ent_t        m_buf[$];
  mreq_t       mem_q[$];

  function automatic bit m_req();
    return (m_phase == 1) && ((m_out.size() + m_buf.size()) < 2) && !redirect_in;
  endfunction

  function automatic bit m_valid();
    return (m_buf.size() > 0) && !redirect_in;
  endfunction

  task automatic model_step();
    bit    req, valid, pop, gnt, resp;
    out_t  r;
    out_t  o;
    ent_t  e;
    mreq_t mq;
    if (rst_in) begin
      m_phase = 0; m_fetch = TB_RESET_PC;
      m_out.delete(); m_buf.delete(); mem_q.delete();
      return;
    end
    req   = m_req();
    valid = m_valid();
    pop   = valid && !stall_in;
    gnt   = req && imem_gnt_in;
    resp  = imem_rvalid_in && (m_out.size() > 0);
    if (imem_rvalid_in && mem_q.size() > 0) mq = mem_q.pop_front();
    if (resp) r = m_out.pop_front();
    if (pop) e = m_buf.pop_front();
    if (resp && !r.stale && !redirect_in) begin
      e.pc = r.pc; e.ins = imem_rdata_in;
      m_buf.push_back(e);
    end
    if (gnt) begin
      o.pc = m_fetch; o.stale = 1'b0;
      m_out.push_back(o);
      mq.addr = m_fetch; mq.due = cyc + $urandom_range(lat_min, lat_max);
      mem_q.push_back(mq);
      m_fetch = m_fetch + 32'd4;
    end
    if (redirect_in) begin
      m_buf.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_fetch = {redirect_pc_in[31:2], 2'b00};
      m_phase = (m_out.size() > 0) ? 2 : 1;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 2 && m_out.size() == 0) begin
      m_phase = 1;
    end
  endtask

  task automatic drive_mem();
    imem_gnt_in = gnt_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_in = 1'b1;
      imem_rdata_in  = mem_q[0].addr + 32'h100;
    end else begin
      imem_rvalid_in = 1'b0;
      imem_rdata_in  = $urandom;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    cyc++;
    redirect_in = 1'b0;
    drive_mem();
  endtask

  task automatic do_reset();
    rst_in = 1'b1; stall_in = 1'b0; redirect_in = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    gnt_always = 1'b1; lat_min = 1; lat_max = 1;
    rst_in = 1'b1;
    tick(); tick();
    #2;
    total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", imem_req_out); end
    total++; if (imem_addr_out !== TB_RESET_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr_out, TB_RESET_PC); end
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_out); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_out); end
    total++; if (instr_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", instr_valid_out); end
    total++; if (flush_out !== 1'b1) begin bad++; $display("FAIL rst_flush got=%0h exp=1", flush_out); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      #2;
      if (k == 0) begin
        total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL boot_req got=%0h exp=0", imem_req_out); end
      end
      if (k == 1) begin
        total++; if (imem_req_out !== 1'b1 || imem_addr_out !== TB_RESET_PC) begin
          bad++; $display("FAIL first_req got req=%0h addr=%h exp req=1 addr=%h", imem_req_out, imem_addr_out, TB_RESET_PC); end
      end
      if (k == 2) begin
        total++; if (instr_valid_out !== 1'b0 || flush_out !== 1'b1) begin
          bad++; $display("FAIL early_valid got valid=%0h flush=%0h exp 0/1", instr_valid_out, flush_out); end
      end
      if (k == 3) begin
        total++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h100) begin
          bad++; $display("FAIL first_instr got v=%0h pc=%h ins=%h exp v=1 pc=0 ins=100", instr_valid_out, pc_out, instr_out); end
      end
      total++; if (imem_req_out !== m_req() || imem_addr_out !== m_fetch) begin
        bad++; $display("FAIL ff_req k=%0d got req=%0h addr=%h exp req=%0h addr=%h", k, imem_req_out, imem_addr_out, m_req(), m_fetch); end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc;
    logic [31:0] exp_pc;
    int consumed;
    for (int i = 0; i < 10 && m_buf.size() == 0; i++) tick();
    held_pc = m_buf[0].pc;
    stall_in = 1'b1;
    for (int s = 0; s < 4; s++) begin
      #2;
      total++; if (instr_valid_out !== 1'b1 || pc_out !== held_pc || instr_out !== held_pc + 32'h100) begin
        bad++; $display("FAIL stall_hold s=%0d got v=%0h pc=%h ins=%h exp pc=%h", s, instr_valid_out, pc_out, instr_out, held_pc); end
      if (s == 3) begin
        total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL stall_full_req got=%0h exp=0", imem_req_out); end
      end
      tick();
    end
    stall_in = 1'b0;
    exp_pc = held_pc;
    consumed = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (instr_valid_out) begin
        total++; if (pc_out !== exp_pc || instr_out !== exp_pc + 32'h100) begin
          bad++; $display("FAIL stall_resume got pc=%h ins=%h exp pc=%h", pc_out, instr_out, exp_pc); end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      tick();
    end
    total++; if (consumed < 8) begin bad++; $display("FAIL stall_rate got=%0d exp>=8", consumed); end
  endtask

  task automatic test_redirect();
    bit seen_req;
    bit seen_valid;
    gnt_always = 1'b1; lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 10 && m_out.size() < 2; i++) tick();
    redirect_in = 1'b1; redirect_pc_in = 32'h0000_0203;
    #2;
    total++; if (flush_out !== 1'b1 || imem_req_out !== 1'b0) begin
      bad++; $display("FAIL redir_cycle got flush=%0h req=%0h exp 1/0", flush_out, imem_req_out); end
    tick();
    seen_req = 1'b0; seen_valid = 1'b0;
    for (int i = 0; i < 30 && !seen_valid; i++) begin
      #2;
      if (imem_req_out && !seen_req) begin
        seen_req = 1'b1;
        total++; if (imem_addr_out !== 32'h200) begin bad++; $display("FAIL redir_addr got=%h exp=00000200", imem_addr_out); end
      end
      if (instr_valid_out) begin
        seen_valid = 1'b1;
        total++; if (pc_out !== 32'h200 || instr_out !== 32'h300) begin
          bad++; $display("FAIL redir_first got pc=%h ins=%h exp pc=200 ins=300", pc_out, instr_out); end
      end
      tick();
    end
    if (!seen_valid) begin total++; bad++; $display("FAIL redir_timeout got=none exp=valid"); end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] tgt;
    logic [31:0] exp_t;
    int drain_left;
    bit seen_valid;
    gnt_always = 1'b1; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 20 && !(imem_rvalid_in && m_buf.size() > 0); i++) tick();
    if (!(imem_rvalid_in && m_buf.size() > 0)) begin
      total++; bad++; $display("FAIL collide_setup got=none exp=rvalid"); return;
    end
    tgt = $urandom;
    exp_t = {tgt[31:2], 2'b00};
    drain_left = m_out.size() - 1;
    stall_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = tgt;
    #2;
    total++; if (instr_valid_out !== 1'b0 || flush_out !== 1'b1 || imem_req_out !== 1'b0) begin
      bad++; $display("FAIL collide_cycle got v=%0h f=%0h req=%0h exp 0/1/0", instr_valid_out, flush_out, imem_req_out); end
    tick();
    stall_in = 1'b0;
    #2;
    if (drain_left == 0) begin
      total++; if (imem_req_out !== 1'b1 || imem_addr_out !== exp_t) begin
        bad++; $display("FAIL collide_next got req=%0h addr=%h exp req=1 addr=%h", imem_req_out, imem_addr_out, exp_t); end
    end else begin
      total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL collide_drain got=%0h exp=0", imem_req_out); end
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 20 && !seen_valid; i++) begin
      tick();
      #2;
      if (instr_valid_out) begin
        seen_valid = 1'b1;
        total++; if (pc_out !== exp_t || instr_out !== exp_t + 32'h100) begin
          bad++; $display("FAIL collide_first got pc=%h ins=%h exp pc=%h", pc_out, instr_out, exp_t); end
      end
    end
    if (!seen_valid) begin total++; bad++; $display("FAIL collide_timeout got=none exp=valid"); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [3];
    int n;
    exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0000_0000;
    gnt_always = 1'b1; lat_min = 1; lat_max = 1;
    do_reset();
    redirect_in = 1'b1; redirect_pc_in = 32'hFFFF_FFF8;
    tick();
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      #2;
      if (imem_req_out && imem_gnt_in) begin
        total++; if (imem_addr_out !== exp_w[n]) begin
          bad++; $display("FAIL wrap_addr n=%0d got=%h exp=%h", n, imem_addr_out, exp_w[n]); end
        n++;
      end
      tick();
    end
    if (n < 3) begin total++; bad++; $display("FAIL wrap_timeout got=%0d exp=3", n); end
  endtask

  task automatic test_reset_midop();
    gnt_always = 1'b1; lat_min = 1; lat_max = 1;
    do_reset();
    stall_in = 1'b1;
    for (int i = 0; i < 20 && m_buf.size() < 2; i++) tick();
    total++; if (instr_valid_out !== 1'b1) begin bad++; $display("FAIL midop_full got=%0h exp=1", instr_valid_out); end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0; stall_in = 1'b0;
    #2;
    total++; if (imem_req_out !== 1'b0 || imem_addr_out !== TB_RESET_PC || instr_out !== 32'h0 ||
                 pc_out !== 32'h0 || instr_valid_out !== 1'b0 || flush_out !== 1'b1) begin
      bad++; $display("FAIL midop_rst got req=%0h addr=%h ins=%h pc=%h v=%0h f=%0h exp 0/%h/0/0/0/1",
                      imem_req_out, imem_addr_out, instr_out, pc_out, instr_valid_out, flush_out, TB_RESET_PC); end
    tick();
    #2;
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== TB_RESET_PC) begin
      bad++; $display("FAIL midop_restart got req=%0h addr=%h exp req=1 addr=%h", imem_req_out, imem_addr_out, TB_RESET_PC); end
  endtask

  task automatic test_random();
    bit prev_redir;
    gnt_always = 1'b0; lat_min = 1; lat_max = 3;
    do_reset();
    prev_redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      stall_in = ($urandom_range(0, 9) < 3);
      redirect_in = !prev_redir && ($urandom_range(0, 19) == 0);
      redirect_pc_in = $urandom;
      prev_redir = redirect_in;
      #2;
      total++; if (imem_req_out !== m_req() || imem_addr_out !== m_fetch) begin
        bad++; $display("FAIL rnd_req c=%0d got req=%0h addr=%h exp req=%0h addr=%h", c, imem_req_out, imem_addr_out, m_req(), m_fetch); end
      total++; if (instr_valid_out !== m_valid() || flush_out !== !m_valid()) begin
        bad++; $display("FAIL rnd_valid c=%0d got v=%0h f=%0h exp v=%0h", c, instr_valid_out, flush_out, m_valid()); end
      if (m_valid()) begin
        total++; if (pc_out !== m_buf[0].pc || instr_out !== m_buf[0].ins) begin
          bad++; $display("FAIL rnd_head c=%0d got pc=%h ins=%h exp pc=%h ins=%h", c, pc_out, instr_out, m_buf[0].pc, m_buf[0].ins); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
